instr_fetch_queue: RTL
======================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of prefetch queue entries (power of two, >= 2).
REQ-002 Parameter RESET_PC, default 64'd0, SHALL set the fetch address loaded on reset.
REQ-003 Parameter MEM_SIZE, default 1024, SHALL set the instruction memory size in bytes (power of two).
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 imem_address  output  64  byte address driven to the combinational instruction memory.
REQ-007 imem_instruction  input  32  instruction word returned combinationally for imem_address.
REQ-008 redirect  input  1  branch/flush request, sampled on the rising edge.
REQ-009 redirect_pc  input  64  new fetch address, valid when redirect=1.
REQ-010 out_valid  output  1  head queue entry is valid.
REQ-011 out_ready  input  1  consumer (decode) accepts the head entry.
REQ-012 out_instr  output  32  instruction of the head entry.
REQ-013 out_pc  output  64  byte address of the head entry.
REQ-014 fault  output  1  sticky fetch fault (misaligned or out-of-bounds fetch address).

Function
REQ-015 imem_address SHALL equal the internal fetch_pc register combinationally, with no added delay.
REQ-016 Push SHALL occur on an edge when fault=0, redirect=0, and (count<DEPTH or a pop occurs on that edge); the push stores {fetch_pc, imem_instruction} and sets fetch_pc <= fetch_pc+4.
REQ-017 Pop SHALL occur on an edge when out_valid=1 and out_ready=1; the head advances by one entry.
REQ-018 Simultaneous push and pop SHALL leave count unchanged, including when count=DEPTH.
REQ-019 out_valid SHALL equal (count != 0); out_instr/out_pc SHALL present the head entry and SHALL be 0 when the queue is empty.
REQ-020 Read/write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide.
REQ-021 Fetch latency SHALL be one edge: an instruction at fetch_pc appears at the queue head on the edge after it is presented, provided the queue was empty.
REQ-022 Redirect SHALL take priority over push and pop: on that edge the queue is emptied (count=0, pointers=0), no push occurs, and fetch_pc <= redirect_pc.
REQ-023 A head entry handshaken in the same cycle as redirect SHALL count as consumed; no entry survives the flush.
REQ-024 When fault=0 and (fetch_pc[1:0]!=0 or fetch_pc+3 >= MEM_SIZE), the edge SHALL set fault=1 instead of pushing, and fetch_pc SHALL hold.
REQ-025 While fault=1, no push SHALL occur; existing entries SHALL drain normally through the handshake.
REQ-026 fault SHALL clear only on redirect or reset; a redirect to a bad address SHALL clear fault for one edge, and the following edge re-evaluates REQ-024.
REQ-027 The block SHALL NOT drive an X or out-of-range address from a state it controls, except the held faulting fetch_pc.

Reset
REQ-028 While reset=0: fetch_pc=RESET_PC, count=0, pointers=0, all entries=0, out_valid=0, out_instr=0, out_pc=0, fault=0.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries immediately, without waiting for a clock edge.
REQ-030 The first push SHALL occur on the first rising edge after reset deasserts.

Structure
REQ-031 A shared package fetch_pkg SHALL hold INSTR_W=32, ADDR_W=64, the default MEM_SIZE, and the packed struct fetch_entry_t {pc[63:0], instr[31:0]}.
REQ-032 The queue storage SHALL be a separate sub-module, fetch_fifo, parameterised by DEPTH and typed on fetch_entry_t, with push/pop/flush inputs.
REQ-033 The PC, fault and push-eligibility logic SHALL reside in instr_fetch_queue.

Verification
REQ-034 Reset release, out_ready=1, memory word k = k -> out_pc sequence 0,4,8,... with out_instr 0,1,2,..., one per cycle after the first edge.
REQ-035 out_ready=0 for 6 edges -> count saturates at 4, fetch_pc stops at 16, out_pc=0 held; then out_ready=1 -> 0,4,8,12,16 delivered in order with no gaps.
REQ-036 Full queue, redirect=1 with redirect_pc=0x100 and out_ready=1 -> next edge count=0, out_valid=0; the following edge out_pc=0x100.
REQ-037 redirect_pc=0x3FC -> 0x3FC delivered, then fault=1 at fetch_pc=0x400 with no further pushes; redirect to 0x0 clears fault.
REQ-038 redirect_pc=0x102 -> fault=1 on the next edge, out_valid=0, imem_address=0x102 held.
REQ-039 reset pulsed low between edges with 3 entries queued -> out_valid=0 immediately; fetch resumes at RESET_PC after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, default memory size and the queue entry layout used by the
// instruction fetch queue and its storage FIFO.
package fetch_pkg;

    localparam int INSTR_W          = 32;
    localparam int ADDR_W           = 64;
    localparam int DEFAULT_MEM_SIZE = 1024;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of fetch entries. Flush empties it in one edge and
// beats push/pop; a push into a full buffer is accepted only alongside a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_wdata,
    output fetch_entry_t o_rdata,
    output logic         o_empty,
    output logic         o_full
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_COUNT);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction prefetcher: walks fetch_pc through a combinational
// instruction memory, buffers {pc, instr} pairs and raises a sticky fault.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'd0,
    parameter int                MEM_SIZE = DEFAULT_MEM_SIZE
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_address,
    input  logic [INSTR_W-1:0] imem_instruction,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               fault
);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_fault;

    logic [ADDR_W:0]   w_last_byte;
    logic              w_bad_pc;
    logic              w_pop;
    logic              w_push;
    logic              w_empty;
    logic              w_full;
    fetch_entry_t      w_wr_entry;
    fetch_entry_t      w_head;

    // One extra bit keeps the bounds test correct for addresses near 2^64.
    assign w_last_byte = {1'b0, r_fetch_pc} + (ADDR_W+1)'(3);
    assign w_bad_pc    = (r_fetch_pc[1:0] != 2'b00) ||
                         (w_last_byte >= (ADDR_W+1)'(MEM_SIZE));

    assign w_pop  = out_valid && out_ready;
    assign w_push = !redirect && !r_fault && !w_bad_pc && (!w_full || w_pop);

    assign w_wr_entry.pc    = r_fetch_pc;
    assign w_wr_entry.instr = imem_instruction;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_fault    <= 1'b0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_fault    <= 1'b0;
        end else if (!r_fault && w_bad_pc) begin
            r_fault    <= 1'b1;
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 64'd4;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_wdata (w_wr_entry),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign imem_address = r_fetch_pc;
    assign out_valid    = !w_empty;
    assign out_pc       = w_head.pc;
    assign out_instr    = w_head.instr;
    assign fault        = r_fault;

endmodule
